// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store sequencer between the execute stage and a byte-lane
//            data memory; sub-word stores are done as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in  [0:3],
    input  logic [7:0]  mem_data_out [0:3],
    output logic        mem_write_en
);

    localparam logic [3:0] c_cnt_last = 4'(MEM_LATENCY - 1);

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_wdata;

    logic        w_req_err;
    logic        w_last_rd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [7:0]  w_merge [0:3];

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign w_last_rd = (r_cnt == c_cnt_last);

    // Request legality is decided from the live request so the accept cycle
    // can route straight to RESP without touching memory.
    always_comb begin
        w_req_err = 1'b1;
        case (req_funct3)
            c_f3_b:  w_req_err = 1'b0;
            c_f3_h:  w_req_err = req_addr[0];
            c_f3_w:  w_req_err = |req_addr[1:0];
            c_f3_bu: w_req_err = req_write;
            c_f3_hu: w_req_err = req_write | req_addr[0];
            default: w_req_err = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = mem_data_out[r_addr_lo];
        w_half = r_addr_lo[1] ? {mem_data_out[3], mem_data_out[2]}
                              : {mem_data_out[1], mem_data_out[0]};
        case (r_funct3)
            c_f3_b:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_f3_h:  w_load_data = {{16{w_half[15]}}, w_half};
            c_f3_bu: w_load_data = {24'h0, w_byte};
            c_f3_hu: w_load_data = {16'h0, w_half};
            default: w_load_data = {mem_data_out[3], mem_data_out[2],
                                    mem_data_out[1], mem_data_out[0]};
        endcase
    end

    // Read-modify-write merge: untouched lanes keep the value just read.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_merge[k] = mem_data_out[k];
        end
        if (r_funct3 == c_f3_b) begin
            w_merge[r_addr_lo] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr_lo[1], 1'b0}] = r_wdata[7:0];
            w_merge[{r_addr_lo[1], 1'b1}] = r_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_wdata      <= 16'h0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'h0;
            mem_addr     <= 32'h0;
            mem_data_in  <= '{default: 8'h00};
            mem_write_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write   <= req_write;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_wdata   <= req_wdata[15:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        r_cnt     <= 4'd0;
                        if (w_req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            r_state    <= ST_RESP;
                        end else if (req_write && req_funct3 == c_f3_w) begin
                            mem_data_in[0] <= req_wdata[7:0];
                            mem_data_in[1] <= req_wdata[15:8];
                            mem_data_in[2] <= req_wdata[23:16];
                            mem_data_in[3] <= req_wdata[31:24];
                            mem_write_en   <= 1'b1;
                            r_state        <= ST_WR;
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_last_rd) begin
                        r_cnt <= 4'd0;
                        if (r_write) begin
                            mem_data_in  <= w_merge;
                            mem_write_en <= 1'b1;
                            r_state      <= ST_WR;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= w_load_data;
                            r_state    <= ST_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WR: begin
                    mem_write_en <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_err     <= 1'b0;
                    resp_rdata   <= 32'h0;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Directed and random load/store sequences against a latency-aware
//            memory model and a byte-level reference of the RISC-V LSU rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy, mem_write_en;
    logic [31:0] resp_rdata, mem_addr;
    logic [7:0]  mem_data_in  [0:3];
    logic [7:0]  mem_data_out [0:3];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_addr = 32'hFFFF_FFFF;
    int          run = 0;
    logic [31:0] in_word;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_LATENCY(L)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_write_en(mem_write_en)
    );

    assign in_word = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

    // Memory: data is only valid once the address has been stable L cycles;
    // before that the lanes carry the inverted word so early sampling shows.
    always @(negedge clk) begin
        logic [31:0] w;
        if (mem_addr === last_addr) run = run + 1;
        else run = 1;
        last_addr = mem_addr;
        w = mem[mem_addr[7:2]];
        if (run < L) w = ~w;
        for (int k = 0; k < 4; k++) mem_data_out[k] = w[8*k +: 8];
    end

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) mem[mem_addr[7:2]] <= in_word;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; expectations come from the RISC-V rules.
    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic hold, output logic [31:0] rd);
        logic [31:0] word, shifted, exp_rd, new_word;
        logic        err;
        int          lat, exp_wcyc, exp_wcnt, cyc, rcyc, wcnt, wcyc, nbytes;
        logic        got;
        word    = ref_mem[addr[7:2]];
        shifted = word >> (8 * addr[1:0]);
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
              (wr && (f3 == 3'd4 || f3 == 3'd5)) ||
              ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ||
              (f3 == 3'd2 && addr[1:0] != 2'd0);
        exp_rd = 32'h0; new_word = word; exp_wcnt = 0; exp_wcyc = 0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            lat = L + 1;
            case (f3)
                3'd0: exp_rd = {{24{shifted[7]}}, shifted[7:0]};
                3'd1: exp_rd = {{16{shifted[15]}}, shifted[15:0]};
                3'd4: exp_rd = {24'h0, shifted[7:0]};
                3'd5: exp_rd = {16'h0, shifted[15:0]};
                default: exp_rd = word;
            endcase
        end else if (f3 == 3'd2) begin
            lat = 2; exp_wcnt = 1; exp_wcyc = 1; new_word = wd;
        end else begin
            lat = L + 2; exp_wcnt = 1; exp_wcyc = L + 1;
            nbytes = (f3 == 3'd0) ? 1 : 2;
            for (int k = 0; k < nbytes; k++)
                new_word[8 * (int'(addr[1:0]) + k) +: 8] = wd[8*k +: 8];
        end

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        chk("ready_before_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        cyc = 1; got = 1'b0; rcyc = 0; wcnt = 0; wcyc = 0; rd = 32'hx;
        while (!got && cyc <= 40) begin
            chk("busy_not_ready", {30'h0, busy, req_ready}, 32'h2);
            if (mem_write_en === 1'b1) begin
                wcnt++; wcyc = cyc;
                chk("write_word", in_word, new_word);
                chk("write_addr", mem_addr, {addr[31:2], 2'b00});
            end
            if (resp_valid === 1'b1) begin
                got = 1'b1; rcyc = cyc; rd = resp_rdata;
                chk("resp_err", {31'h0, resp_err}, {31'h0, err});
                chk("resp_rdata", resp_rdata, exp_rd);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("resp_seen", {31'h0, got}, 32'h1);
        chk("resp_cycle", rcyc, lat);
        chk("write_count", wcnt, exp_wcnt);
        chk("write_cycle", wcyc, exp_wcyc);
        @(posedge clk); #1;
        chk("idle_after_resp", {30'h0, resp_valid, req_ready}, 32'h1);
        if (!err && wr) ref_mem[addr[7:2]] = new_word;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  f;
        rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_lanes", in_word, 32'h0);
        chk("rst_write_en", {31'h0, mem_write_en}, 32'h0);
        chk("rst_busy_ready", {30'h0, busy, req_ready}, 32'h1);
        @(negedge clk); rst_b = 1'b1;

        do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0, rd);
        do_op(1'b0, 3'd2, 32'h100, 32'h0, 1'b0, rd);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        do_op(1'b1, 3'd2, 32'h104, 32'h0000_80FF, 1'b0, rd);
        do_op(1'b0, 3'd0, 32'h105, 32'h0, 1'b0, rd);
        chk("lb_sign", rd, 32'hFFFF_FF80);
        do_op(1'b0, 3'd4, 32'h105, 32'h0, 1'b0, rd);
        chk("lbu_zero", rd, 32'h0000_0080);
        do_op(1'b1, 3'd2, 32'h108, 32'h8001_0000, 1'b0, rd);
        do_op(1'b0, 3'd1, 32'h10A, 32'h0, 1'b0, rd);
        chk("lh_sign", rd, 32'hFFFF_8001);
        do_op(1'b0, 3'd5, 32'h10A, 32'h0, 1'b0, rd);
        chk("lhu_zero", rd, 32'h0000_8001);

        do_op(1'b1, 3'd2, 32'h10C, 32'h4433_2211, 1'b0, rd);
        do_op(1'b1, 3'd0, 32'h10F, 32'hAAAA_AA12, 1'b0, rd);
        do_op(1'b0, 3'd2, 32'h10C, 32'h0, 1'b0, rd);
        chk("sb_merge", rd, 32'h1233_2211);

        do_op(1'b0, 3'd2, 32'h102, 32'h0, 1'b0, rd);
        do_op(1'b1, 3'd1, 32'h101, 32'h5555, 1'b0, rd);
        do_op(1'b0, 3'd3, 32'h100, 32'h0, 1'b0, rd);
        do_op(1'b1, 3'd4, 32'h100, 32'h0, 1'b0, rd);

        // Back-to-back with req_valid held high between ops.
        for (int i = 0; i < 6; i++) begin
            a = 32'h140 + 32'($urandom_range(0, 63));
            do_op(1'($urandom), 3'($urandom_range(0, 2)), a & ~32'h3, $urandom, 1'b1, rd);
        end

        for (int i = 0; i < 80; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 255));
            f = 3'($urandom);
            do_op(1'($urandom), f, a, $urandom, 1'($urandom), rd);
        end

        // Reset one cycle into an SB: the store must vanish without a trace.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h1F1; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_lanes", in_word, 32'h0);
        chk("abort_write_en", {31'h0, mem_write_en}, 32'h0);
        chk("abort_busy_ready", {30'h0, busy, req_ready}, 32'h1);
        @(negedge clk); rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", {30'h0, resp_valid, mem_write_en}, 32'h0);
        end
        chk("abort_mem_word", mem[6'h3C], ref_mem[6'h3C]);
        do_op(1'b0, 3'd2, 32'h1F0, 32'h0, 1'b0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
